// File: rtl/tx_burst_ctrl.sv
// tx_burst_ctrl: paces input-FIFO reads into the MSK modulator for one frame, then drains a
// fixed tail before pulsing done. Optional FILL watchdog enabled by defining TX_TIMEOUT_EN.
module tx_burst_ctrl #(
    parameter int FRAME_W        = 8,
    parameter int COUNT_W        = 8,
    parameter int TAIL_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               inClock,
    input  logic               inReset,
    input  logic               inStart,
    input  logic [FRAME_W-1:0] inFrameLen,
    input  logic [COUNT_W-1:0] inFifoCount,
    input  logic               inFifoEmpty,
    input  logic               inCoderReady,
    output logic               outFifoReadEnable,
    output logic               outCoderEmpty,
    output logic               outBusy,
    output logic               outDone,
    output logic               outUnderflow,
    output logic               outTimeout,
    output logic [FRAME_W-1:0] outBitCount,
    output logic [2:0]         outState
);

    // Handshake: inCoderReady is a request with no back-pressure. Every cycle it is high in
    // SEND with the FIFO non-empty yields exactly one outFifoReadEnable one cycle later.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        SEND = 3'd2,
        TAIL = 3'd3,
        DONE = 3'd4
    } stateType;

    localparam int CMP_W  = (FRAME_W > COUNT_W) ? FRAME_W : COUNT_W;
    localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);

    if (TAIL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gParamCheck
        $error("tx_burst_ctrl: TAIL_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    stateType           state;
    stateType           nextState;
    logic [FRAME_W-1:0] frameLen;
    logic [FRAME_W-1:0] bitCount;
    logic [FRAME_W-1:0] bitNext;
    logic [TAIL_W-1:0]  tailCount;
    logic [CMP_W-1:0]   countExt;
    logic [CMP_W-1:0]   lenExt;
    logic               readEnable;
    logic               underflow;
    logic               zeroDone;
    logic               fillReady;
    logic               timeoutExpired;
    logic               acceptStart;
    logic               zeroStart;
    logic               issueBit;
    logic               underflowHit;

    assign countExt  = CMP_W'(inFifoCount);
    assign lenExt    = CMP_W'(frameLen);
    assign fillReady = (countExt >= lenExt);
    assign bitNext   = bitCount + FRAME_W'(1);

    always_comb begin
        nextState    = state;
        acceptStart  = 1'b0;
        zeroStart    = 1'b0;
        issueBit     = 1'b0;
        underflowHit = 1'b0;
        case (state)
            IDLE: begin
                if (inStart) begin
                    if (inFrameLen != '0) begin
                        acceptStart = 1'b1;
                        nextState   = FILL;
                    end else begin
                        zeroStart = 1'b1;
                    end
                end
            end
            FILL: begin
                if (fillReady)           nextState = SEND;
                else if (timeoutExpired) nextState = DONE;
            end
            SEND: begin
                if (inCoderReady) begin
                    if (inFifoEmpty) begin
                        // Truncate the frame rather than stall the modulator mid-burst.
                        underflowHit = 1'b1;
                        nextState    = TAIL;
                    end else begin
                        issueBit = 1'b1;
                        if (bitNext == frameLen) nextState = TAIL;
                    end
                end
            end
            TAIL: begin
                if (tailCount == TAIL_W'(TAIL_CYCLES - 1)) nextState = DONE;
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) state <= IDLE;
        else          state <= nextState;
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            frameLen   <= '0;
            bitCount   <= '0;
            readEnable <= 1'b0;
            underflow  <= 1'b0;
            zeroDone   <= 1'b0;
            tailCount  <= '0;
        end else begin
            readEnable <= issueBit;
            zeroDone   <= zeroStart;
            if (acceptStart) begin
                frameLen  <= inFrameLen;
                bitCount  <= '0;
                underflow <= 1'b0;
            end else begin
                if (issueBit)     bitCount  <= bitNext;
                if (underflowHit) underflow <= 1'b1;
            end
            if (state == TAIL) tailCount <= tailCount + TAIL_W'(1);
            else               tailCount <= '0;
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] fillCycles;
    logic            timeoutFlag;

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            fillCycles  <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            if (state == FILL) fillCycles <= fillCycles + TO_W'(1);
            else               fillCycles <= '0;
            if (acceptStart)
                timeoutFlag <= 1'b0;
            else if (state == FILL && !fillReady && timeoutExpired)
                timeoutFlag <= 1'b1;
        end
    end

    assign timeoutExpired = (fillCycles == TO_W'(TIMEOUT_CYCLES - 1));
    assign outTimeout     = timeoutFlag;
`else
    assign timeoutExpired = 1'b0;
    assign outTimeout     = 1'b0;
`endif

    assign outFifoReadEnable = readEnable;
    assign outCoderEmpty     = (state != SEND);
    assign outBusy           = (state != IDLE);
    assign outDone           = (state == DONE) | zeroDone;
    assign outUnderflow      = underflow;
    assign outBitCount       = bitCount;
    assign outState          = state;

endmodule
